// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode multiplexed 7-segment scanner.
// Latches one BCD word per frame, blanks leading zeros, renders the sign
// as '-' (or as the digit-3 decimal point when no room) and inserts one
// dark cycle at every digit switch so no segment pattern ghosts.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] bcd_in,
    input  logic        negative,
    input  logic        blank_lz,
    output logic [3:0]  anodes,
    output logic [6:0]  segments,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      dig_q, dig_d;
    logic [15:0]     word_q, word_d;
    logic            neg_q, neg_d;
    logic [3:0]      anodes_q, anodes_d;
    logic [6:0]      segments_q, segments_d;
    logic            dp_q, dp_d;
    logic            frame_tick_q, frame_tick_d;

    logic            slot_end;
    logic            wrap;
    logic [3:0]      blank;
    logic [3:0][6:0] glyph;
    logic [3:0]      dp_n;

    // BCD nibble to active-low glyph; non-decimal nibbles show 'E'.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0000110;
        endcase
    endfunction

    // Scan counters and frame latch; enable low freezes the scan and
    // makes the latch transparent so re-enable starts with fresh data.
    always_comb begin
        slot_end     = (pre_q == PRE_MAX);
        wrap         = enable && slot_end && (dig_q == 2'd3);
        pre_d        = pre_q;
        dig_d        = dig_q;
        word_d       = word_q;
        neg_d        = neg_q;
        frame_tick_d = wrap;
        if (enable) begin
            pre_d = slot_end ? '0 : pre_q + 1'b1;
            if (slot_end)
                dig_d = dig_q + 2'd1;
        end
        if (!enable || wrap) begin
            word_d = bcd_in;
            neg_d  = negative;
        end
    end

    // Leading-zero blanking chain from the top digit down; digit 0 always shows.
    always_comb begin
        blank    = '0;
        blank[3] = blank_lz && (word_q[15:12] == 4'd0);
        for (int k = 2; k >= 1; k--)
            blank[k] = blank[k+1] && (word_q[4*k +: 4] == 4'd0);
    end

    // Per-digit glyph: the lowest blanked digit carries the minus sign.
    always_comb begin
        glyph = '0;
        dp_n  = 4'hF;
        glyph[0] = decode(word_q[3:0]);
        for (int k = 1; k < 4; k++) begin
            if (!blank[k])
                glyph[k] = decode(word_q[4*k +: 4]);
            else if (neg_q && !blank[k-1])
                glyph[k] = SEG_MINUS;
            else
                glyph[k] = SEG_OFF;
        end
        // No blanked digit to hold the sign: fall back to digit-3 dp.
        dp_n[3] = !(neg_q && !blank[3]);
    end

    // Output mux: dark when disabled, anodes dark during the dead-time cycle.
    always_comb begin
        anodes_d   = 4'hF;
        segments_d = SEG_OFF;
        dp_d       = 1'b1;
        if (enable) begin
            segments_d = glyph[dig_q];
            dp_d       = dp_n[dig_q];
            if (pre_q != '0)
                anodes_d = ~(4'b0001 << dig_q);
        end
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            dig_q        <= '0;
            word_q       <= '0;
            neg_q        <= 1'b0;
            anodes_q     <= 4'hF;
            segments_q   <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            dig_q        <= dig_d;
            word_q       <= word_d;
            neg_q        <= neg_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anodes     = anodes_q;
    assign segments   = segments_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
